data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single 64-bit data memory (Memoria64 instance) between two requesters:
  - port 0: CPU datapath load/store path, driven by UC.
  - port 1: debug/boot loader that preloads or inspects data memory.
- Sits between the requesters and the memory. Round-robin arbitration, one access in flight at a time.
- Drives stall_cpu back to UC so the multicycle FSM holds its state while waiting.

Parameters:
- ADDR_W, 64, address width of both ports and the memory.
- DATA_W, 64, data width.
- RD_LAT, 1, memory read latency in cycles (range 1..7).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  CPU access request; held until cpu_gnt
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  DATA_W  store data (Reg_B value)
- cpu_gnt  out  1  one-cycle pulse: CPU access accepted
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
- cpu_rdata  out  DATA_W  load data
- stall_cpu  out  1  cpu_req & ~cpu_done; UC holds state while high
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  same semantics, port 1
- dbg_gnt, dbg_rvalid  out  1  same semantics, port 1
- dbg_rdata  out  DATA_W  same semantics, port 1
- mem_addr  out  ADDR_W  to memory raddress and waddress
- mem_wdata  out  DATA_W  to memory Datain
- mem_wr  out  1  to memory Wr
- mem_rdata  in  DATA_W  from memory Dataout
- busy  out  1  high in RD_WAIT

Behaviour:
- Reset is reset, asynchronous, active-high; clock is clock.
- Reset values: state=IDLE, last_gnt=1, lat_cnt=0, addr_q=0, owner_q=0.
- While reset is high, all gnt/rvalid/mem_wr/busy/stall_cpu outputs are 0 and mem_addr/mem_wdata are 0.
- States: IDLE, RD_WAIT.
- IDLE, no request: mem_wr=0, mem_addr=0, no grants.
- IDLE, winner selection:
  - Only one req high: that port wins.
  - Both high: the port != last_gnt wins. The first tie after reset goes to CPU.
- IDLE, winner's gnt is a combinational pulse in the same cycle. mem_addr/mem_wdata mux the winner's addr/wdata combinationally. last_gnt<=winner.
- Winner write (we=1):
  - mem_wr=1 this cycle only.
  - Write completes at this edge; state stays IDLE.
  - A new grant is possible the next cycle (back-to-back writes, 1 per cycle).
- Winner read (we=0):
  - mem_wr=0; addr_q<=addr, owner_q<=winner, lat_cnt<=RD_LAT-1; go to RD_WAIT.
- RD_WAIT:
  - mem_addr=addr_q, mem_wr=0, busy=1, no grants issued; requests are held by requesters.
  - lat_cnt>0: decrement.
  - lat_cnt==0: rvalid of owner_q=1 and its rdata=mem_rdata (combinational pass-through), then go to IDLE.
  - With RD_LAT=1 this means rvalid occurs in the cycle after gnt.
- rdata of a non-owner port holds its last delivered value. Reset value of cpu_rdata/dbg_rdata is 0 (registered capture at the rvalid edge; rdata output = mem_rdata during the rvalid cycle, else the captured value).
- cpu_done = cpu_gnt for writes, cpu_rvalid for reads. stall_cpu=1 from cpu_req rising until that cycle; 0 in the done cycle.
- Requester contract: hold req/we/addr/wdata stable until gnt; deassert or present a new request the cycle after gnt. The arbiter does not check this.
- A request arriving during RD_WAIT waits; it is considered in the first IDLE cycle after rvalid (one idle-turnaround cycle between reads).
- Reset asserted mid-read: the read is abandoned, no rvalid is issued, and last_gnt returns to 1.
- Width rules:
  - No address translation: addresses pass through unmodified.
  - Byte/half/word cutting remains in the existing load/store trim blocks, outside this block.

Test Plan:
- cpu_req=1, cpu_we=1, addr=0x10, wdata=0xDEAD -> cpu_gnt and mem_wr high in the same cycle, mem_addr=0x10; a later dbg read of 0x10 returns 0xDEAD.
- dbg read 0x20 (mem holds 0x1234), RD_LAT=1 -> dbg_gnt at cycle t, dbg_rvalid at t+1 with dbg_rdata=0x1234, busy=1 at t+1.
- cpu_req and dbg_req both held high after reset, writes -> grants alternate CPU, DBG, CPU, DBG on consecutive cycles.
- dbg read in progress (RD_LAT=3), cpu write requested mid-read -> cpu_gnt only in the IDLE cycle after dbg_rvalid; stall_cpu=1 for every cycle until then; mem_wr never high during RD_WAIT.
- reset pulse during RD_WAIT -> no rvalid, outputs 0 immediately (asynchronous); after release, a first tie grants CPU.
- RD_LAT=3 CPU read -> cpu_rvalid exactly 3 cycles after cpu_gnt; mem_addr stable at addr_q throughout.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin two-port arbiter in front of the 64-bit data memory
module data_mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall_cpu,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    // Counter preload so that rvalid lands exactly RD_LAT cycles after the grant.
    localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

    state_t            state, state_nx;
    logic              last_gnt, last_gnt_nx;   // 0 = CPU, 1 = debug
    logic [2:0]        lat_cnt, lat_cnt_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic              owner_q, owner_nx;       // port that owns the read in flight
    logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
    logic              winner;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;

    // State and bookkeeping registers; reset abandons any read in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_gnt    <= 1'b1;
            lat_cnt     <= 3'd0;
            addr_q      <= '0;
            owner_q     <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state    <= state_nx;
            last_gnt <= last_gnt_nx;
            lat_cnt  <= lat_cnt_nx;
            addr_q   <= addr_nx;
            owner_q  <= owner_nx;
            if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
            if (dbg_rvalid) dbg_rdata_q <= mem_rdata;
        end
    end

    // Arbitration, memory muxing and next-state; all outputs forced low while reset is high.
    always_comb begin
        state_nx    = state;
        last_gnt_nx = last_gnt;
        lat_cnt_nx  = lat_cnt;
        addr_nx     = addr_q;
        owner_nx    = owner_q;
        cpu_gnt     = 1'b0;
        dbg_gnt     = 1'b0;
        cpu_rvalid  = 1'b0;
        dbg_rvalid  = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wr      = 1'b0;
        busy        = 1'b0;
        // On a tie the port that did not win last time goes first.
        winner      = (cpu_req && dbg_req) ? ~last_gnt : dbg_req;
        win_we      = winner ? dbg_we : cpu_we;
        win_addr    = winner ? dbg_addr : cpu_addr;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (cpu_req || dbg_req) begin
                        cpu_gnt     = ~winner;
                        dbg_gnt     = winner;
                        mem_addr    = win_addr;
                        mem_wdata   = winner ? dbg_wdata : cpu_wdata;
                        mem_wr      = win_we;
                        last_gnt_nx = winner;
                        if (!win_we) begin
                            addr_nx    = win_addr;
                            owner_nx   = winner;
                            lat_cnt_nx = LAT_INIT;
                            state_nx   = RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    mem_addr = addr_q;
                    busy     = 1'b1;
                    if (lat_cnt != 3'd0) begin
                        lat_cnt_nx = lat_cnt - 3'd1;
                    end else begin
                        cpu_rvalid = ~owner_q;
                        dbg_rvalid = owner_q;
                        state_nx   = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Read data passes straight through in the rvalid cycle, otherwise the last delivered value.
    assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_rdata_q;

    // UC stalls from request until the access is done: grant for stores, rvalid for loads.
    assign stall_cpu = ~reset & cpu_req & ~((cpu_gnt & cpu_we) | cpu_rvalid);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    // Instance A: RD_LAT=1
    logic        cpu_req_a, cpu_we_a, dbg_req_a, dbg_we_a;
    logic [63:0] cpu_addr_a, cpu_wdata_a, dbg_addr_a, dbg_wdata_a;
    logic        cpu_gnt_a, cpu_rvalid_a, stall_cpu_a, dbg_gnt_a, dbg_rvalid_a, mem_wr_a, busy_a;
    logic [63:0] cpu_rdata_a, dbg_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic [63:0] mem_a [0:255];

    // Instance B: RD_LAT=3
    logic        cpu_req_b, cpu_we_b, dbg_req_b, dbg_we_b;
    logic [63:0] cpu_addr_b, cpu_wdata_b, dbg_addr_b, dbg_wdata_b;
    logic        cpu_gnt_b, cpu_rvalid_b, stall_cpu_b, dbg_gnt_b, dbg_rvalid_b, mem_wr_b, busy_b;
    logic [63:0] cpu_rdata_b, dbg_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic [63:0] mem_b [0:255];

    data_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LAT(1)) u_a (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req_a), .cpu_we(cpu_we_a), .cpu_addr(cpu_addr_a), .cpu_wdata(cpu_wdata_a),
        .cpu_gnt(cpu_gnt_a), .cpu_rvalid(cpu_rvalid_a), .cpu_rdata(cpu_rdata_a), .stall_cpu(stall_cpu_a),
        .dbg_req(dbg_req_a), .dbg_we(dbg_we_a), .dbg_addr(dbg_addr_a), .dbg_wdata(dbg_wdata_a),
        .dbg_gnt(dbg_gnt_a), .dbg_rvalid(dbg_rvalid_a), .dbg_rdata(dbg_rdata_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_wr(mem_wr_a), .mem_rdata(mem_rdata_a),
        .busy(busy_a)
    );

    data_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LAT(3)) u_b (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_addr(cpu_addr_b), .cpu_wdata(cpu_wdata_b),
        .cpu_gnt(cpu_gnt_b), .cpu_rvalid(cpu_rvalid_b), .cpu_rdata(cpu_rdata_b), .stall_cpu(stall_cpu_b),
        .dbg_req(dbg_req_b), .dbg_we(dbg_we_b), .dbg_addr(dbg_addr_b), .dbg_wdata(dbg_wdata_b),
        .dbg_gnt(dbg_gnt_b), .dbg_rvalid(dbg_rvalid_b), .dbg_rdata(dbg_rdata_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_wr(mem_wr_b), .mem_rdata(mem_rdata_b),
        .busy(busy_b)
    );

    // Memory models: combinational read, write on the rising edge.
    assign mem_rdata_a = mem_a[mem_addr_a[7:0]];
    assign mem_rdata_b = mem_b[mem_addr_b[7:0]];
    always @(posedge clock) if (mem_wr_a) mem_a[mem_addr_a[7:0]] <= mem_wdata_a;
    always @(posedge clock) if (mem_wr_b) mem_b[mem_addr_b[7:0]] <= mem_wdata_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic cr, input logic cw, input logic [63:0] ca, input logic [63:0] cd,
                         input logic dr, input logic dw, input logic [63:0] da, input logic [63:0] dd);
        cpu_req_a = cr; cpu_we_a = cw; cpu_addr_a = ca; cpu_wdata_a = cd;
        dbg_req_a = dr; dbg_we_a = dw; dbg_addr_a = da; dbg_wdata_a = dd;
    endtask

    task automatic set_b(input logic cr, input logic cw, input logic [63:0] ca, input logic [63:0] cd,
                         input logic dr, input logic dw, input logic [63:0] da, input logic [63:0] dd);
        cpu_req_b = cr; cpu_we_b = cw; cpu_addr_b = ca; cpu_wdata_b = cd;
        dbg_req_b = dr; dbg_we_b = dw; dbg_addr_b = da; dbg_wdata_b = dd;
    endtask

    // Each step: wait for the falling edge, drive the new cycle, settle, then check.
    task automatic step;
        @(negedge clock);
    endtask

    initial begin
        // Reset held with a pending request: nothing may leak out.
        set_a(1, 1, 64'h10, 64'hDEAD, 0, 0, 0, 0);
        set_b(1, 0, 64'h18, 0, 1, 0, 64'h20, 0);
        step; #1;
        chk("rst_cpu_gnt_a", cpu_gnt_a, 0);
        chk("rst_mem_wr_a", mem_wr_a, 0);
        chk("rst_mem_addr_a", mem_addr_a, 0);
        chk("rst_mem_wdata_a", mem_wdata_a, 0);
        chk("rst_stall_a", stall_cpu_a, 0);
        chk("rst_gnts_b", {cpu_gnt_b, dbg_gnt_b, busy_b, stall_cpu_b}, 0);
        chk("rst_rdata_b", cpu_rdata_b, 0);

        // Idle with no request.
        step; reset = 1'b0;
        set_a(0, 0, 0, 0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("idle_mem_addr_a", mem_addr_a, 0);
        chk("idle_gnt_a", {cpu_gnt_a, dbg_gnt_a, mem_wr_a}, 0);

        // CPU store 0xDEAD to 0x10: grant and write in the same cycle.
        step; set_a(1, 1, 64'h10, 64'hDEAD, 0, 0, 0, 0); #1;
        chk("wr_cpu_gnt", cpu_gnt_a, 1);
        chk("wr_mem_wr", mem_wr_a, 1);
        chk("wr_mem_addr", mem_addr_a, 64'h10);
        chk("wr_mem_wdata", mem_wdata_a, 64'hDEAD);
        chk("wr_stall", stall_cpu_a, 0);

        // CPU store 0x1234 to 0x20, back to back.
        step; set_a(1, 1, 64'h20, 64'h1234, 0, 0, 0, 0); #1;
        chk("wr2_cpu_gnt", cpu_gnt_a, 1);
        chk("wr2_mem_addr", mem_addr_a, 64'h20);

        // Debug read of 0x10 returns the stored value one cycle after grant.
        step; set_a(0, 0, 0, 0, 1, 0, 64'h10, 0); #1;
        chk("rd10_gnt", dbg_gnt_a, 1);
        chk("rd10_mem_wr", mem_wr_a, 0);
        step; set_a(0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("rd10_rvalid", dbg_rvalid_a, 1);
        chk("rd10_rdata", dbg_rdata_a, 64'hDEAD);
        chk("rd10_busy", busy_a, 1);

        // Debug read of 0x20 (holds 0x1234).
        step; set_a(0, 0, 0, 0, 1, 0, 64'h20, 0); #1;
        chk("rd20_gnt", dbg_gnt_a, 1);
        chk("rd20_rvalid_t", dbg_rvalid_a, 0);
        chk("rd20_hold_prev", dbg_rdata_a, 64'hDEAD);
        step; set_a(0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("rd20_rvalid", dbg_rvalid_a, 1);
        chk("rd20_rdata", dbg_rdata_a, 64'h1234);
        chk("rd20_busy", busy_a, 1);
        chk("rd20_mem_addr", mem_addr_a, 64'h20);
        step; #1;
        chk("rd20_held", dbg_rdata_a, 64'h1234);
        chk("rd20_busy_off", busy_a, 0);
        chk("cpu_rdata_untouched", {63'd0, cpu_rvalid_a} | cpu_rdata_a, 0);

        // Reset pulse, then both ports write continuously: CPU, DBG, CPU, DBG.
        step; reset = 1'b1;
        step; reset = 1'b0;
        set_a(1, 1, 64'h30, 64'hC0, 1, 1, 64'h38, 64'hD0); #1;
        chk("rr0_cpu", cpu_gnt_a, 1);
        chk("rr0_dbg", dbg_gnt_a, 0);
        step; #1;
        chk("rr1_pair", {cpu_gnt_a, dbg_gnt_a, stall_cpu_a}, 3'b011);
        chk("rr1_addr", mem_addr_a, 64'h38);
        step; #1;
        chk("rr2_pair", {cpu_gnt_a, dbg_gnt_a, stall_cpu_a}, 3'b100);
        step; #1;
        chk("rr3_pair", {cpu_gnt_a, dbg_gnt_a, stall_cpu_a}, 3'b011);
        step; set_a(0, 0, 0, 0, 0, 0, 0, 0);

        // RD_LAT=3: preload 0x40, debug read, CPU store requested mid-read.
        set_b(0, 0, 0, 0, 1, 1, 64'h40, 64'h55AA); #1;
        chk("b_pre_gnt", dbg_gnt_b, 1);
        step; set_b(0, 0, 0, 0, 1, 0, 64'h40, 0); #1;
        chk("b_rd_gnt", dbg_gnt_b, 1);
        step; set_b(1, 1, 64'h48, 64'h77, 0, 0, 0, 0); #1;
        chk("b_w1", {busy_b, cpu_gnt_b, stall_cpu_b, mem_wr_b, dbg_rvalid_b}, 5'b10100);
        chk("b_w1_addr", mem_addr_b, 64'h40);
        step; #1;
        chk("b_w2", {busy_b, cpu_gnt_b, stall_cpu_b, mem_wr_b, dbg_rvalid_b}, 5'b10100);
        step; #1;
        chk("b_w3", {busy_b, cpu_gnt_b, stall_cpu_b, mem_wr_b, dbg_rvalid_b}, 5'b10101);
        chk("b_rdata", dbg_rdata_b, 64'h55AA);
        step; #1;
        chk("b_turn", {busy_b, cpu_gnt_b, stall_cpu_b, mem_wr_b, dbg_rvalid_b}, 5'b01010);
        chk("b_turn_addr", mem_addr_b, 64'h48);
        chk("b_turn_wdata", mem_wdata_b, 64'h77);

        // RD_LAT=3 CPU read of 0x48, request held until rvalid.
        step; set_b(1, 0, 64'h48, 0, 0, 0, 0, 0); #1;
        chk("c_gnt", {cpu_gnt_b, stall_cpu_b}, 2'b11);
        step; #1;
        chk("c_w1", {cpu_rvalid_b, stall_cpu_b, cpu_gnt_b}, 3'b010);
        chk("c_w1_addr", mem_addr_b, 64'h48);
        step; #1;
        chk("c_w2", {cpu_rvalid_b, stall_cpu_b, cpu_gnt_b}, 3'b010);
        chk("c_w2_addr", mem_addr_b, 64'h48);
        step; #1;
        chk("c_rv", {cpu_rvalid_b, stall_cpu_b, cpu_gnt_b}, 3'b100);
        chk("c_rdata", cpu_rdata_b, 64'h77);
        chk("c_rv_addr", mem_addr_b, 64'h48);
        step; set_b(0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("c_after", {cpu_rvalid_b, cpu_gnt_b, busy_b}, 0);
        chk("c_held", cpu_rdata_b, 64'h77);

        // Reset in the middle of a RD_LAT=3 read: abandoned, outputs drop at once.
        step; set_b(0, 0, 0, 0, 1, 0, 64'h40, 0); #1;
        chk("r_gnt", dbg_gnt_b, 1);
        step; set_b(0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("r_busy", busy_b, 1);
        #2 reset = 1'b1; #1;
        chk("r_async_busy", busy_b, 0);
        chk("r_async_addr", mem_addr_b, 0);
        step; reset = 1'b0; #1;
        chk("r_post0", {dbg_rvalid_b, busy_b}, 0);
        chk("r_rdata_cleared", dbg_rdata_b, 0);
        step; #1;
        chk("r_post1", {dbg_rvalid_b, busy_b}, 0);
        step; set_b(1, 1, 64'h50, 64'h1, 1, 1, 64'h58, 64'h2); #1;
        chk("r_tie_cpu", {cpu_gnt_b, dbg_gnt_b}, 2'b10);
        step; set_b(0, 0, 0, 0, 0, 0, 0, 0); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
